// File: rtl/mv_pkg.sv
// Shared types and constants for the systolic matrix-vector engine.
package mv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int clog2(input int value);
    int bits = 0;
    int rest = value - 1;
    while (rest > 0) begin
      bits++;
      rest = rest >> 1;
    end
    return bits;
  endfunction

  localparam int DW_DEF = 8;
  localparam int N_DEF  = 4;
  localparam int AW_DEF = 2 * DW_DEF + clog2(N_DEF);

endpackage

// File: rtl/mv_systolic_engine_if.sv
// Start/busy/done handshake plus operand and result buses of the engine.
interface mv_systolic_engine_if
  import mv_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
);

  logic              start;
  logic              hold;
  logic [N*N*DW-1:0] mat;
  logic [N*DW-1:0]   vec;
  logic              busy;
  logic              done;
  logic [N*AW-1:0]   res;

  modport master (output start, hold, mat, vec, input busy, done, res);
  modport slave  (input start, hold, mat, vec, output busy, done, res);

endinterface

// File: rtl/mv_mac_pe.sv
// One systolic row: DWxDW multiply, AW-bit accumulate, and a vector pass register.
module mv_mac_pe #(
  parameter int DW     = 8,
  parameter int AW     = 18,
  parameter int SIGNED = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic          act,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] v_in,
  output logic [DW-1:0] v_out,
  output logic [AW-1:0] acc_nxt
);

  logic [AW-1:0] prod;
  logic [AW-1:0] acc;

  // The full 2*DW product is formed first, then extended or wrapped to AW.
  if (SIGNED != 0) begin : g_signed
    logic signed [2*DW-1:0] p;
    assign p    = $signed({{DW{a[DW-1]}}, a}) * $signed({{DW{v_in[DW-1]}}, v_in});
    assign prod = AW'(p);
  end else begin : g_unsigned
    logic [2*DW-1:0] p;
    assign p    = {{DW{1'b0}}, a} * {{DW{1'b0}}, v_in};
    assign prod = AW'(p);
  end

  assign acc_nxt = (en && act) ? acc + prod : acc;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      acc   <= '0;
      v_out <= '0;
    end else if (en) begin
      acc   <= acc_nxt;
      v_out <= v_in;
    end
  end

endmodule

// File: rtl/mv_systolic_engine.sv
// N x N matrix-vector multiplier: FSM, step counter, operand capture and row-window decode.
module mv_systolic_engine
  import mv_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int DW     = DW_DEF,
  parameter int AW     = AW_DEF,
  parameter int SIGNED = 0
) (
  input logic                clk,
  input logic                rst,
  mv_systolic_engine_if.slave bus
);

  localparam int            TW     = clog2(2 * N);
  localparam int            KW     = (N > 1) ? clog2(N) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(2 * N - 2);

  state_t          state;
  logic [TW-1:0]   t;
  logic            busy_q;
  logic            done_q;
  logic [N*AW-1:0] res_q;
  logic [N*AW-1:0] res_nxt;
  logic            load;
  logic            step;

  logic [DW-1:0] m_q   [N][N];
  logic [DW-1:0] v_q   [N];
  logic [DW-1:0] chain [N];
  logic [AW-1:0] acc_nxt [N];

  assign load = (state == IDLE) && bus.start;
  assign step = (state == RUN) && !bus.hold;

  // NOTE: operand registers carry no reset; they are only read after a start has loaded them.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int r = 0; r < N; r++) begin
        v_q[r] <= bus.vec[r*DW +: DW];
        for (int k = 0; k < N; k++) begin
          m_q[r][k] <= bus.mat[(r*N+k)*DW +: DW];
        end
      end
    end
  end

  for (genvar r = 0; r < N; r++) begin : g_row
    logic          act;
    logic [KW-1:0] k;
    logic [DW-1:0] a_sel;
    logic [DW-1:0] v_in;

    // Row r consumes column k = t - r during steps r .. r+N-1.
    assign act   = (t >= TW'(r)) && (t <= TW'(r + N - 1));
    assign k     = KW'(t - TW'(r));
    assign a_sel = act ? m_q[r][k] : '0;

    if (r == 0) begin : g_head
      assign v_in = act ? v_q[k] : '0;
    end else begin : g_link
      assign v_in = chain[r-1];
    end

    mv_mac_pe #(
      .DW     (DW),
      .AW     (AW),
      .SIGNED (SIGNED)
    ) u_pe (
      .clk     (clk),
      .rst     (rst),
      .clr     (load),
      .en      (step),
      .act     (act),
      .a       (a_sel),
      .v_in    (v_in),
      .v_out   (chain[r]),
      .acc_nxt (acc_nxt[r])
    );

    assign res_nxt[r*AW +: AW] = acc_nxt[r];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      t      <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      res_q  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= RUN;
            t      <= '0;
            busy_q <= 1'b1;
          end
        end
        RUN: begin
          if (!bus.hold) begin
            if (t == T_LAST) begin
              state  <= DONE;
              done_q <= 1'b1;
              res_q  <= res_nxt;
            end else begin
              t <= t + TW'(1);
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          t      <= '0;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.res  = res_q;

endmodule

// File: tb/tb_mv_systolic_engine.sv
// Self-checking bench: unsigned and signed engines driven in lockstep against a sum-of-products model.
module tb_mv_systolic_engine;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 18;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [DW-1:0] m_v [N][N];
  logic [DW-1:0] v_v [N];

  mv_systolic_engine_if #(.N(N), .DW(DW), .AW(AW)) u_if ();
  mv_systolic_engine_if #(.N(N), .DW(DW), .AW(AW)) s_if ();

  assign s_if.start = u_if.start;
  assign s_if.hold  = u_if.hold;
  assign s_if.mat   = u_if.mat;
  assign s_if.vec   = u_if.vec;

  mv_systolic_engine #(.N(N), .DW(DW), .AW(AW), .SIGNED(0)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  mv_systolic_engine #(.N(N), .DW(DW), .AW(AW), .SIGNED(1)) s_dut (
    .clk (clk),
    .rst (rst),
    .bus (s_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Y[r] = sum_k M[r][k] * V[k], reduced modulo 2^AW.
  function automatic logic [AW-1:0] model_y(input int r, input bit sgn);
    longint acc = 0;
    longint a;
    longint b;
    for (int k = 0; k < N; k++) begin
      a = sgn ? longint'($signed(m_v[r][k])) : longint'(m_v[r][k]);
      b = sgn ? longint'($signed(v_v[k]))    : longint'(v_v[k]);
      acc += a * b;
    end
    return AW'(acc);
  endfunction

  task automatic apply_operands();
    for (int r = 0; r < N; r++) begin
      u_if.vec[r*DW +: DW] = v_v[r];
      for (int k = 0; k < N; k++) u_if.mat[(r*N+k)*DW +: DW] = m_v[r][k];
    end
  endtask

  task automatic randomize_operands();
    for (int r = 0; r < N; r++) begin
      v_v[r] = DW'($urandom);
      for (int k = 0; k < N; k++) m_v[r][k] = DW'($urandom);
    end
  endtask

  task automatic check_results(input string tag);
    for (int r = 0; r < N; r++) begin
      check($sformatf("%s_u_y%0d", tag, r), 32'(u_if.res[r*AW +: AW]), 32'(model_y(r, 1'b0)));
      check($sformatf("%s_s_y%0d", tag, r), 32'(s_if.res[r*AW +: AW]), 32'(model_y(r, 1'b1)));
    end
  endtask

  // One operation; hold is raised after edge hold_at for hold_len edges; poke exercises ignored starts.
  task automatic do_op(input string tag, input int hold_at, input int hold_len, input bit poke);
    int n;
    bit seen;
    apply_operands();
    u_if.start = 1'b1;
    @(negedge clk);
    u_if.start = 1'b0;
    if (poke) begin
      for (int i = 0; i < N*N; i++) u_if.mat[i*DW +: DW] = DW'($urandom);
      u_if.vec = ~u_if.vec;
    end
    check({tag, "_busy_run"}, 32'(u_if.busy), 32'd1);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 60) begin
      if (n == hold_at) u_if.hold = 1'b1;
      if (n == hold_at + hold_len) u_if.hold = 1'b0;
      u_if.start = poke && (n == 3);
      @(negedge clk);
      n++;
      seen = (u_if.done === 1'b1);
    end
    u_if.hold  = 1'b0;
    u_if.start = 1'b0;
    check({tag, "_latency"}, 32'(n), 32'(2*N - 1 + hold_len));
    check({tag, "_busy_done"}, 32'(u_if.busy), 32'd1);
    check({tag, "_s_done"}, 32'(s_if.done), 32'd1);
    check_results(tag);
    u_if.start = poke;
    @(negedge clk);
    u_if.start = 1'b0;
    check({tag, "_done_width"}, 32'(u_if.done), 32'd0);
    check({tag, "_busy_idle"}, 32'(u_if.busy), 32'd0);
    if (poke) begin
      @(negedge clk);
      check({tag, "_no_restart"}, 32'(u_if.busy), 32'd0);
    end
  endtask

  initial begin
    rst        = 1'b0;
    u_if.start = 1'b0;
    u_if.hold  = 1'b0;
    u_if.mat   = '0;
    u_if.vec   = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(u_if.busy), 32'd0);
    check("rst_done", 32'(u_if.done), 32'd0);
    check("rst_res",  32'(|u_if.res), 32'd0);
    check("rst_s_res", 32'(|s_if.res), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int r = 0; r < N; r++) begin
      v_v[r] = DW'(r + 1);
      for (int k = 0; k < N; k++) m_v[r][k] = (r == k) ? 8'd1 : 8'd0;
    end
    do_op("ident", -1, 0, 1'b0);
    check("ident_y3", 32'(u_if.res[3*AW +: AW]), 32'd4);

    for (int r = 0; r < N; r++) begin
      v_v[r] = 8'hFF;
      for (int k = 0; k < N; k++) m_v[r][k] = 8'hFF;
    end
    do_op("full", -1, 0, 1'b0);
    check("full_u_y0", 32'(u_if.res[0 +: AW]), 32'd260100);

    for (int r = 0; r < N; r++) begin
      v_v[r] = 8'h80;
      for (int k = 0; k < N; k++) m_v[r][k] = 8'h80;
    end
    do_op("neg", -1, 0, 1'b0);
    check("neg_s_y1", 32'(s_if.res[AW +: AW]), 32'd65536);

    randomize_operands();
    for (int k = 0; k < N; k++) v_v[k] = 8'd1;
    m_v[0][0] = 8'h7F;
    m_v[0][1] = 8'h80;
    m_v[0][2] = 8'h01;
    m_v[0][3] = 8'hFF;
    do_op("mixed", -1, 0, 1'b0);
    check("mixed_s_y0", 32'(s_if.res[0 +: AW]), 32'h3FFFF);

    randomize_operands();
    do_op("nohold", -1, 0, 1'b0);
    do_op("hold", 2, 3, 1'b0);

    randomize_operands();
    do_op("poke", -1, 0, 1'b1);

    randomize_operands();
    apply_operands();
    u_if.start = 1'b1;
    @(negedge clk);
    u_if.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(u_if.busy), 32'd0);
    check("abort_done", 32'(u_if.done), 32'd0);
    check("abort_res",  32'(|u_if.res), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    do_op("fresh", -1, 0, 1'b0);

    for (int i = 0; i < 5; i++) begin
      randomize_operands();
      do_op($sformatf("rand%0d", i), (i == 2) ? 0 : -1, (i == 2) ? 2 : 0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mv_systolic_engine.md
# mv_systolic_engine

Parametrised N×N matrix–vector multiplier built as a one-dimensional systolic array of N multiply-accumulate processing elements (PEs), one per matrix row. It supersedes the fixed 4×4, 8-bit row-skewed multiplier in the compute datapath. It adds configurable dimension, operand and accumulator widths, signed/unsigned mode, a start/busy/done handshake, a stall input and full-precision results.

## Interface
- N, default 4: matrix dimension, i.e. PE count; legal range 1..16.
- DW, default 8: operand width in bits.
- AW, default 18: accumulator/result width; 2·DW+clog2(N) gives exact results, and a smaller AW wraps modulo 2^AW.
- SIGNED, default 0: 0 means unsigned operands; 1 means two's-complement operands and results.
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  reset, synchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- hold  in  1  stall; freezes RUN progress while high.
- mat  in  N·N·DW  matrix; element M[r][k] sits at bits [(r·N+k+1)·DW-1 : (r·N+k)·DW].
- vec  in  N·DW  vector; element V[k] sits at bits [(k+1)·DW-1 : k·DW].
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse in DONE.
- res  out  N·AW  result; Y[r] sits at bits [(r+1)·AW-1 : r·AW].

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE→RUN on a clk edge with start=1:
  - mat and vec are captured into internal registers.
  - All accumulators clear.
  - Step counter t←0.
  - mat/vec may change freely afterwards.
- RUN, on each edge with hold=0:
  - Every PE r with r ≤ t ≤ r+N-1 computes acc_r ← acc_r + M[r][t-r]·V[t-r].
  - V[t-r] reaches PE r through a DW-bit register chain (PE r-1 → PE r), giving a one-step skew per row.
  - t increments.
- RUN with hold=1: t, the accumulators and the chain registers are unchanged.
- RUN→DONE on the edge that processes t=2N-2. On that same edge res is loaded from the final accumulator values.
- DONE→IDLE unconditionally on the next edge.
- start is ignored when the FSM is not in IDLE. start during DONE is ignored.
- Arithmetic: products are 2·DW bits, sign- or zero-extended to AW per SIGNED. Accumulation is modulo 2^AW with no saturation.
- res holds its value until the next DONE entry. It is not cleared by start.
- N=1: RUN lasts exactly one step.

## Timing
- Reset (rst=0 at an edge) forces:
  - state=IDLE, t=0, busy=0, done=0, res=0.
  - All accumulators and chain registers to 0.
- Reset mid-RUN aborts the operation with no done pulse.
- Latency with no hold: start sampled at edge E0 → busy high from E0 → res valid and done=1 after edge E(2N-1) → busy low after E(2N).
- For N=4, done is high during the 7th cycle after the start edge.
- Each hold cycle in RUN adds exactly one cycle of latency.
- hold has no effect in IDLE or DONE.
- Back-to-back operation: the earliest accepted next start is on the edge after DONE. This gives a throughput of one operation per 2N+1 cycles.
- done and busy are registered outputs with no combinational path from inputs.

## Structure
- Package mv_pkg holds:
  - The state enum: IDLE, RUN, DONE.
  - A clog2 function.
  - Default parameter constants DW_DEF=8, N_DEF=4 and AW_DEF = 2·DW_DEF+clog2(N_DEF).
- Sub-module mv_mac_pe is instantiated N times in a generate loop. It contains:
  - The DW×DW multiplier with SIGNED selection.
  - The AW accumulator with clear and enable.
  - The pass-through vector register.
- The top level holds the FSM, the step counter, the operand capture registers and the per-row active-window decode.

## Test plan
- **Identity:** N=4, DW=8, M=I, V=(1,2,3,4), start → done after 2N-1 edges; res=(1,2,3,4); busy deasserts one cycle after done.
- **Unsigned full scale:** all M and V = 255 → every Y=260100 (fits AW=18); done pulse exactly one cycle wide.
- **Signed mode:** SIGNED=1, all M and V = -128 → every Y=65536; M row 0 = (127,-128,1,-1) with V all 1 → Y[0]=-1.
- **Handshake:**
  - start pulsed during RUN and during DONE → ignored, with exactly one done.
  - mat changed one cycle after start → result reflects the captured values.
- **Hold:** 3 hold cycles inserted at t=2 → done delayed by exactly 3 cycles; result identical to the no-hold run.
- **Reset mid-run:** rst=0 at t=3 → next cycle busy=0, done=0, res=0; a fresh start then completes correctly.
